// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants and control bundle for the ID stage.
// The ID_WB_BYPASS_EN option is handled in the register file, not here.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic       illegal;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Register file: two combinational reads, one synchronous write, $0 hard-wired to 0.
// Define ID_WB_BYPASS_EN to make a same-cycle read of the written register return wb data.
module regfile_nr #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  localparam logic [5:0] NREGS_L = 6'(NREGS);

  // Storage is sized for the full address space; entries at or above NREGS
  // are never written and so stay at their reset value.
  logic [DATA_W-1:0] regs [32];
  logic              wr_ok;

  assign wr_ok = we && (wa != 5'd0) && ({1'b0, wa} < NREGS_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a != 5'd0 && {1'b0, a} < NREGS_L) begin
`ifdef ID_WB_BYPASS_EN
      if (wr_ok && wa == a) v = wd;
      else                  v = regs[a];
`else
      v = regs[a];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rd1 = rd_port(ra1);
    rd2 = rd_port(ra2);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS-style ID stage: decode, load-use hazard detection and the ID/EX register.
// Optional ID_WB_BYPASS_EN selects write-first register reads.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  input  logic              flush_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_illegal,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd
);

  // Handshake: in_valid qualifies instruction. While stall_out is high the
  // upstream holds instruction/in_valid steady and ID/EX takes a bubble;
  // the instruction is accepted on the first edge where stall_out is low.
  // ID/EX itself never sees backpressure.

  logic [5:0]        op;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_sext, rs_data, rt_data;
  ctrl_t             ctrl_d, ctrl_q;
  logic              hazard, load_bubble;

  assign op       = instruction[31:26];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign imm_sext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign ctrl_d   = decode_op(op);

  regfile_nr #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .we    (wb_we),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  // lw and addi only use rt as a destination, so a matching rt is no hazard.
  always_comb begin
    hazard = in_valid && ex_valid && ctrl_q.mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == rs) || ((ex_rt == rt) && (op != OP_LW) && (op != OP_ADDI)));
  end

  assign stall_out   = hazard && !flush_in;
  assign load_bubble = flush_in || hazard || !in_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid   <= 1'b0;
      ctrl_q     <= '0;
      ex_imm     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (load_bubble) begin
      ex_valid   <= 1'b0;
      ctrl_q     <= '0;
      ex_imm     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else begin
      ex_valid   <= 1'b1;
      ctrl_q     <= ctrl_d;
      ex_imm     <= imm_sext;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_rd      <= rd;
    end
  end

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_illegal    = ctrl_q.illegal;
  assign ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus random traffic
// against a behavioural model; honours ID_WB_BYPASS_EN like the design.
module tb_id_stage_pipe;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;   // reg_write,mem_to_reg,branch,mem_write,mem_read,alu_src,reg_dst,illegal,alu_op
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [14:0] regs;   // rs,rt,rd
  } ex_t;
  localparam int W = $bits(ex_t);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] instruction = '0;
  logic in_valid = 1'b0, flush_in = 1'b0, wb_we = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic stall_out, ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write;
  logic ex_mem_read, ex_alu_src, ex_reg_dst, ex_illegal;
  logic [1:0] ex_alu_op;
  logic [DATA_W-1:0] ex_imm, ex_rs_data, ex_rt_data;
  logic [4:0] ex_rs, ex_rt, ex_rd;

  int n_checks = 0;
  int n_fail = 0;
  logic last_stall;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m_regs [32];
  ex_t          m_ex;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
    .flush_in(flush_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_ctrl();
    return {ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write, ex_mem_read,
            ex_alu_src, ex_reg_dst, ex_illegal, ex_alu_op};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0 || int'(a) >= NREGS) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  // Control word by instruction class, listed in output order.
  function automatic logic [9:0] m_controls(input logic [5:0] op);
    case (op)
      6'h00:   return 10'b1000001_0_10; // R-type: write rd, funct ALU
      6'h23:   return 10'b1100110_0_00; // lw
      6'h2B:   return 10'b0001010_0_00; // sw
      6'h04:   return 10'b0010000_0_01; // beq
      6'h08:   return 10'b1000010_0_00; // addi
      default: return 10'b0000000_1_00; // illegal
    endcase
  endfunction

  function automatic logic m_hazard(input logic [31:0] ins, input logic v);
    logic [4:0] rs, rt;
    logic rt_is_source;
    rs = ins[25:21];
    rt = ins[20:16];
    rt_is_source = !(ins[31:26] == 6'h23 || ins[31:26] == 6'h08);
    return v && m_ex.valid && m_ex.ctrl[5] && m_ex.regs[9:5] != 0 &&
           (m_ex.regs[9:5] == rs || (rt_is_source && m_ex.regs[9:5] == rt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ex = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic [31:0] ins, input logic v, input logic f,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_t nxt, got, e;
    logic hz;
    @(negedge clk);
    instruction = ins; in_valid = v; flush_in = f;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    hz = m_hazard(ins, v);
    last_stall = stall_out;
    check_eq("stall_out", 32'(stall_out), 32'(hz && !f));
    nxt = '0;
    if (v && !f && !hz) begin
      nxt.valid   = 1'b1;
      nxt.ctrl    = m_controls(ins[31:26]);
      nxt.imm     = 32'($signed(ins[15:0]));
      nxt.rs_data = m_read(ins[25:21], we, wa, wd);
      nxt.rt_data = m_read(ins[20:16], we, wa, wd);
      nxt.regs    = ins[25:11];
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (we && wa != 0 && int'(wa) < NREGS) m_regs[wa] = wd;
    m_ex = nxt;
    e = exp_q.pop_front();
    got = '{valid: ex_valid, ctrl: dut_ctrl(), imm: ex_imm, rs_data: ex_rs_data,
            rt_data: ex_rt_data, regs: {ex_rs, ex_rt, ex_rd}};
    check_eq("ex_valid", 32'(got.valid), 32'(e.valid));
    check_eq("ex_ctrl", 32'(got.ctrl), 32'(e.ctrl));
    check_eq("ex_imm", got.imm, e.imm);
    check_eq("ex_rs_data", got.rs_data, e.rs_data);
    check_eq("ex_rt_data", got.rt_data, e.rt_data);
    check_eq("ex_regnums", 32'(got.regs), 32'(e.regs));
  endtask

  task automatic idle_cycle();
    do_cycle(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic check_ex_cleared(input string tag);
    check_eq({tag, "_valid"}, 32'(ex_valid), 32'd0);
    check_eq({tag, "_ctrl"}, 32'(dut_ctrl()), 32'd0);
    check_eq({tag, "_data"}, ex_imm | ex_rs_data | ex_rt_data, 32'd0);
    check_eq({tag, "_regs"}, 32'({ex_rs, ex_rt, ex_rd}), 32'd0);
  endtask

  function automatic logic [4:0] rnd_reg();
    return 5'($urandom_range(0, 19));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] op;
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h00};
    op = ops[$urandom_range(0, 5)];
    if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
    return {op, rnd_reg(), rnd_reg(), 16'($urandom())};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    check_ex_cleared("reset");
    check_eq("reset_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();  // release edge with in_valid=0 must not issue

    // Seed registers, including addresses beyond NREGS that must read 0.
    for (int i = 1; i < 20; i++)
      do_cycle(32'h0, 1'b0, 1'b0, 1'b1, 5'(i), $urandom());

    // addi with negative immediate
    do_cycle(32'h2022FFFC, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("addi_imm", ex_imm, 32'hFFFFFFFC);
    check_eq("addi_alu_src", 32'(ex_alu_src), 32'd1);
    check_eq("addi_alu_op", 32'(ex_alu_op), 32'd0);

    // load-use: one stall, one bubble, then issue
    idle_cycle();
    do_cycle(32'h8D280004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    do_cycle(32'h010B5020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("lu_stall", 32'(last_stall), 32'd1);
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    do_cycle(32'h010B5020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("lu_release", 32'(last_stall), 32'd0);
    check_eq("lu_issue", 32'(ex_valid), 32'd1);
    check_eq("lu_ex_rs", 32'(ex_rs), 32'd8);

    // load into $0 never stalls
    idle_cycle();
    do_cycle(32'h8D200004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    do_cycle(32'h00005020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("lw0_stall", 32'(last_stall), 32'd0);
    check_eq("lw0_issue", 32'(ex_valid), 32'd1);

    // same-cycle write-back and read of $5
    do_cycle(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000ABCD);
    do_cycle(32'h00A05020, 1'b1, 1'b0, 1'b1, 5'd5, 32'h00001234);
`ifdef ID_WB_BYPASS_EN
    check_eq("wb_same_cycle", ex_rs_data, 32'h00001234);
`else
    check_eq("wb_same_cycle", ex_rs_data, 32'h0000ABCD);
`endif
    do_cycle(32'h00A05020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("wb_next_cycle", ex_rs_data, 32'h00001234);

    // flush during a load-use hazard, then an illegal opcode
    idle_cycle();
    do_cycle(32'h8D280004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    do_cycle(32'h010B5020, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    check_eq("flush_stall", 32'(last_stall), 32'd0);
    check_eq("flush_bubble", 32'(ex_valid), 32'd0);
    do_cycle(32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("illegal_flag", 32'(ex_illegal), 32'd1);
    check_eq("illegal_ctrl", 32'(dut_ctrl()), 32'h004);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      do_cycle(rnd_instr(), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 2) == 0), rnd_reg(), $urandom());
    end

    // reset mid-run while an instruction sits in ID/EX
    idle_cycle();
    do_cycle(32'h20030007, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("pre_reset_valid", 32'(ex_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; wb_we = 1'b0; flush_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_ex_cleared("midrun_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_cycle();
    do_cycle(32'h00A65020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);  // reads $5,$6
    check_eq("post_reset_rs", ex_rs_data, 32'd0);
    check_eq("post_reset_rt", ex_rt_data, 32'd0);
    for (int n = 0; n < 50; n++) begin
      do_cycle(rnd_instr(), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1) == 0), rnd_reg(), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
